// File: rtl/prom_cmd_arbiter_pkg.sv
// Shared types for the PROM command arbiter: port indices, command/address widths,
// FSM state encoding and the two-port grant selection helper.
package prom_arb_pkg;

  localparam int CMD_W     = 4;
  localparam int ADDR_W    = 6;
  localparam int NUM_PORTS = 2;
  localparam int PORT_A    = 0;
  localparam int PORT_B    = 1;

  typedef logic [CMD_W-1:0]     cmd_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [NUM_PORTS-1:0] grant_t;

  typedef struct packed {
    cmd_t  cmd;
    addr_t addr;
  } prom_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4,
    ST_TMO       = 3'd5
  } state_t;

  // Auto-load locks out port B; otherwise a tie goes to the port not served last.
  function automatic grant_t arb_pick(input logic a_req, input logic b_req,
                                      input logic al_ena, input logic last_b);
    grant_t g;
    g = '0;
    if (a_req && (al_ena || !b_req || last_b))
      g[PORT_A] = 1'b1;
    else if (b_req && !al_ena)
      g[PORT_B] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/prom_cmd_arbiter_if.sv
// Request ports A/B plus the executor handshake; master is the arbiter's view,
// slave is the view of the surrounding requesters and executor.
interface prom_cmd_arbiter_if;
  import prom_arb_pkg::*;

  logic   AL_ENA;
  logic   A_REQ;
  cmd_t   A_CMD;
  addr_t  A_ADDR;
  logic   A_ACK;
  logic   B_REQ;
  cmd_t   B_CMD;
  addr_t  B_ADDR;
  logic   B_ACK;
  logic   EXECUTE;
  cmd_t   CMD;
  addr_t  ADDR;
  logic   BUSY;
  grant_t GRANT;
  logic   XFER_ERR;
  logic   TIMEOUT_ERR;
  logic   CLR_ERR;

  modport master (
    input  AL_ENA, A_REQ, A_CMD, A_ADDR, B_REQ, B_CMD, B_ADDR, BUSY, CLR_ERR,
    output A_ACK, B_ACK, EXECUTE, CMD, ADDR, GRANT, XFER_ERR, TIMEOUT_ERR
  );

  modport slave (
    output AL_ENA, A_REQ, A_CMD, A_ADDR, B_REQ, B_CMD, B_ADDR, BUSY, CLR_ERR,
    input  A_ACK, B_ACK, EXECUTE, CMD, ADDR, GRANT, XFER_ERR, TIMEOUT_ERR
  );

endinterface

// File: rtl/prom_cmd_arbiter_busy_watchdog.sv
// Saturating 16-bit wait counter; the hit flags mean "this counted cycle is the limit-th".
// Combinational compares on a registered count, so a hit is visible in the same cycle.
module busy_watchdog #(
  parameter logic [3:0]  START_WAIT = 4'd8,
  parameter logic [15:0] TMO_CYC    = 16'd50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic start_hit,
  output logic done_hit
);

  logic [15:0] cnt;
  logic [16:0] cnt_p1;

  always_ff @(posedge CLK) begin
    if (RST || clr)
      cnt <= '0;
    else if (inc && (cnt != 16'hFFFF))
      cnt <= cnt + 16'd1;
  end

  always_comb begin
    cnt_p1    = {1'b0, cnt} + 17'd1;
    start_hit = (cnt_p1 >= {13'd0, START_WAIT});
    done_hit  = (cnt_p1 >= {1'b0, TMO_CYC});
  end

endmodule

// File: rtl/prom_cmd_arbiter.sv
// Two-port arbiter feeding a single PROM command executor: GRANT one cycle after a winning
// request, EXECUTE one cycle later, ACK after BUSY falls or a watchdog timeout.
module prom_cmd_arbiter
  import prom_arb_pkg::*;
#(
  parameter logic [3:0]  START_WAIT = 4'd8,
  parameter logic [15:0] TMO_CYC    = 16'd50000
) (
  input logic               CLK,
  input logic               RST,
  prom_cmd_arbiter_if.master bus
);

  state_t    state;
  grant_t    grant;
  grant_t    pick;
  prom_cmd_t cmd_q;
  logic      execute;
  logic      a_ack;
  logic      b_ack;
  logic      xfer_err;
  logic      timeout_err;
  logic      last_b;
  logic      wd_clr;
  logic      wd_inc;
  logic      start_hit;
  logic      done_hit;

  always_comb begin
    pick   = arb_pick(bus.A_REQ, bus.B_REQ, bus.AL_ENA, last_b);
    // Counter restarts on entry to each wait state, including the Wait_Busy -> Wait_Done hop.
    wd_clr = (state == ST_IDLE) || (state == ST_ISSUE) ||
             ((state == ST_WAIT_BUSY) && bus.BUSY);
    wd_inc = ((state == ST_WAIT_BUSY) && !bus.BUSY) ||
             ((state == ST_WAIT_DONE) && bus.BUSY);
  end

  busy_watchdog #(
    .START_WAIT (START_WAIT),
    .TMO_CYC    (TMO_CYC)
  ) u_wd (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (wd_clr),
    .inc       (wd_inc),
    .start_hit (start_hit),
    .done_hit  (done_hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      grant       <= '0;
      cmd_q       <= '0;
      execute     <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      xfer_err    <= 1'b0;
      timeout_err <= 1'b0;
      last_b      <= 1'b1;
    end else begin
      execute  <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      xfer_err <= 1'b0;
      if (bus.CLR_ERR)
        timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!bus.BUSY && (pick != '0)) begin
            grant  <= pick;
            last_b <= pick[PORT_B];
            if (pick[PORT_B]) begin
              cmd_q.cmd  <= bus.B_CMD;
              cmd_q.addr <= bus.B_ADDR;
            end else begin
              cmd_q.cmd  <= bus.A_CMD;
              cmd_q.addr <= bus.A_ADDR;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          execute <= 1'b1;
          state   <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          if (bus.BUSY) begin
            state <= ST_WAIT_DONE;
          end else if (start_hit) begin
            a_ack       <= grant[PORT_A];
            b_ack       <= grant[PORT_B];
            xfer_err    <= 1'b1;
            timeout_err <= 1'b1;
            state       <= ST_TMO;
          end
        end

        ST_WAIT_DONE: begin
          if (!bus.BUSY) begin
            a_ack <= grant[PORT_A];
            b_ack <= grant[PORT_B];
            state <= ST_ACK;
          end else if (done_hit) begin
            // Placed after the CLR_ERR handling so a coincident clear loses.
            a_ack       <= grant[PORT_A];
            b_ack       <= grant[PORT_B];
            xfer_err    <= 1'b1;
            timeout_err <= 1'b1;
            state       <= ST_TMO;
          end
        end

        ST_ACK, ST_TMO: begin
          grant <= '0;
          state <= ST_IDLE;
        end

        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.GRANT       = grant;
  assign bus.EXECUTE     = execute;
  assign bus.CMD         = cmd_q.cmd;
  assign bus.ADDR        = cmd_q.addr;
  assign bus.A_ACK       = a_ack;
  assign bus.B_ACK       = b_ack;
  assign bus.XFER_ERR    = xfer_err;
  assign bus.TIMEOUT_ERR = timeout_err;

endmodule

// File: tb/tb_prom_cmd_arbiter.sv
// Directed bench for prom_cmd_arbiter: START_WAIT=8, TMO_CYC=20, inputs driven and
// outputs sampled 1 time unit after each rising edge.
module tb_prom_cmd_arbiter;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  prom_cmd_arbiter_if ifc ();

  prom_cmd_arbiter #(
    .START_WAIT (4'd8),
    .TMO_CYC    (16'd20)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expects a grant at the next edge, runs BUSY for two samples, drops the owner's REQ on ACK.
  task automatic serve(input string tag, input logic [1:0] g, input logic [3:0] c,
                       input logic [5:0] a);
    tick();
    chk({tag, "_grant"}, 16'(ifc.GRANT), 16'(g));
    chk({tag, "_cmdaddr"}, 16'({ifc.CMD, ifc.ADDR}), 16'({c, a}));
    chk({tag, "_exec_lo"}, 16'(ifc.EXECUTE), 16'd0);
    tick();
    chk({tag, "_exec_hi"}, 16'(ifc.EXECUTE), 16'd1);
    ifc.BUSY = 1'b1;
    tick();
    tick();
    ifc.BUSY = 1'b0;
    tick();
    chk({tag, "_ack"}, 16'({ifc.B_ACK, ifc.A_ACK}), 16'(g));
    chk({tag, "_xerr"}, 16'(ifc.XFER_ERR), 16'd0);
    if (g[0]) ifc.A_REQ = 1'b0;
    else      ifc.B_REQ = 1'b0;
    tick();
    chk({tag, "_idle"}, 16'({ifc.GRANT, ifc.B_ACK, ifc.A_ACK}), 16'd0);
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    ifc.AL_ENA = 1'b0; ifc.BUSY = 1'b0; ifc.CLR_ERR = 1'b0;
    ifc.A_REQ = 1'b0; ifc.A_CMD = 4'h0; ifc.A_ADDR = 6'h00;
    ifc.B_REQ = 1'b0; ifc.B_CMD = 4'h0; ifc.B_ADDR = 6'h00;
    tick();
    tick();
    chk("rst_outs", 16'({ifc.GRANT, ifc.EXECUTE, ifc.A_ACK, ifc.B_ACK, ifc.XFER_ERR,
                         ifc.TIMEOUT_ERR}), 16'd0);
    chk("rst_cmdaddr", 16'({ifc.CMD, ifc.ADDR}), 16'd0);
    RST = 1'b0;
    tick();

    // Basic command: A, CMD 3, ADDR 21, BUSY high five cycles; REQ dropped after grant.
    ifc.A_REQ = 1'b1; ifc.A_CMD = 4'h3; ifc.A_ADDR = 6'h21;
    tick();
    chk("t1_grant", 16'(ifc.GRANT), 16'd1);
    chk("t1_exec_lo", 16'(ifc.EXECUTE), 16'd0);
    chk("t1_cmdaddr", 16'({ifc.CMD, ifc.ADDR}), 16'({4'h3, 6'h21}));
    tick();
    chk("t1_exec_hi", 16'(ifc.EXECUTE), 16'd1);
    ifc.BUSY = 1'b1; ifc.A_REQ = 1'b0; ifc.A_CMD = 4'hF; ifc.A_ADDR = 6'h00;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen += int'(ifc.A_ACK) + int'(ifc.EXECUTE);
    end
    chk("t1_quiet_busy", 16'(seen), 16'd0);
    chk("t1_hold", 16'({ifc.GRANT, ifc.CMD, ifc.ADDR}), 16'({2'b01, 4'h3, 6'h21}));
    ifc.BUSY = 1'b0;
    tick();
    chk("t1_ack", 16'({ifc.B_ACK, ifc.A_ACK, ifc.XFER_ERR}), 16'b010);
    tick();
    chk("t1_idle", 16'({ifc.GRANT, ifc.A_ACK}), 16'd0);

    // No arbitration while the executor is still busy.
    ifc.BUSY = 1'b1; ifc.B_REQ = 1'b1; ifc.B_CMD = 4'h2; ifc.B_ADDR = 6'h3A;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen += int'(ifc.GRANT != 2'b00);
    end
    chk("busy_gate_nogrant", 16'(seen), 16'd0);
    ifc.BUSY = 1'b0;
    serve("busy_gate_b", 2'b10, 4'h2, 6'h3A);

    // Round-robin from reset: A wins first tie, then B; after a lone A, B wins the tie.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ifc.A_REQ = 1'b1; ifc.A_CMD = 4'h1; ifc.A_ADDR = 6'h05;
    ifc.B_REQ = 1'b1; ifc.B_CMD = 4'h2; ifc.B_ADDR = 6'h3A;
    serve("tie1_a", 2'b01, 4'h1, 6'h05);
    serve("tie1_b", 2'b10, 4'h2, 6'h3A);
    ifc.A_REQ = 1'b1;
    serve("lone_a", 2'b01, 4'h1, 6'h05);
    ifc.A_REQ = 1'b1; ifc.B_REQ = 1'b1;
    serve("tie2_b", 2'b10, 4'h2, 6'h3A);
    serve("tie2_a", 2'b01, 4'h1, 6'h05);

    // Auto-load locks out B across three A commands; B goes once the lock lifts.
    ifc.AL_ENA = 1'b1; ifc.B_REQ = 1'b1;
    tick();
    chk("al_b_blocked", 16'(ifc.GRANT), 16'd0);
    for (int i = 0; i < 3; i++) begin
      ifc.A_REQ = 1'b1; ifc.A_CMD = 4'(i + 4); ifc.A_ADDR = 6'(i + 8);
      serve("al_a", 2'b01, 4'(i + 4), 6'(i + 8));
    end
    tick();
    chk("al_b_still_blocked", 16'(ifc.GRANT), 16'd0);
    ifc.AL_ENA = 1'b0;
    serve("al_off_b", 2'b10, 4'h2, 6'h3A);

    // BUSY never rises: timeout on the 8th Wait_Busy cycle.
    ifc.A_REQ = 1'b1; ifc.A_CMD = 4'h7; ifc.A_ADDR = 6'h0C;
    tick();
    chk("sw_grant", 16'(ifc.GRANT), 16'd1);
    tick();
    chk("sw_exec", 16'(ifc.EXECUTE), 16'd1);
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen += int'(ifc.A_ACK);
    end
    chk("sw_no_early_ack", 16'(seen), 16'd0);
    tick();
    chk("sw_tmo_ack", 16'({ifc.A_ACK, ifc.XFER_ERR, ifc.TIMEOUT_ERR}), 16'b111);
    ifc.A_REQ = 1'b0;
    tick();
    chk("sw_after", 16'({ifc.GRANT, ifc.A_ACK, ifc.XFER_ERR, ifc.TIMEOUT_ERR}), 16'b00001);
    tick();
    tick();
    chk("sw_sticky", 16'(ifc.TIMEOUT_ERR), 16'd1);
    ifc.CLR_ERR = 1'b1;
    tick();
    ifc.CLR_ERR = 1'b0;
    chk("sw_cleared", 16'(ifc.TIMEOUT_ERR), 16'd0);

    // BUSY stuck high: timeout after 20 Wait_Done cycles; CLR_ERR on that edge loses.
    ifc.A_REQ = 1'b1; ifc.A_CMD = 4'h9; ifc.A_ADDR = 6'h11;
    tick();
    tick();
    chk("bd_exec", 16'(ifc.EXECUTE), 16'd1);
    ifc.BUSY = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen += int'(ifc.A_ACK);
    end
    chk("bd_no_early_ack", 16'(seen), 16'd0);
    ifc.CLR_ERR = 1'b1;
    tick();
    chk("bd_tmo_ack", 16'({ifc.A_ACK, ifc.XFER_ERR, ifc.TIMEOUT_ERR}), 16'b111);
    ifc.CLR_ERR = 1'b0; ifc.A_REQ = 1'b0; ifc.BUSY = 1'b0;
    tick();
    chk("bd_set_wins", 16'({ifc.GRANT, ifc.TIMEOUT_ERR}), 16'b001);

    // Reset in Wait_Done with BUSY high: no ACK, no grant until BUSY falls.
    ifc.A_REQ = 1'b1; ifc.A_CMD = 4'h4; ifc.A_ADDR = 6'h02;
    tick();
    tick();
    ifc.BUSY = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("mid_rst_outs", 16'({ifc.GRANT, ifc.EXECUTE, ifc.A_ACK, ifc.B_ACK, ifc.XFER_ERR,
                             ifc.TIMEOUT_ERR}), 16'd0);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen += int'(ifc.GRANT != 2'b00) + int'(ifc.A_ACK);
    end
    chk("mid_rst_hold", 16'(seen), 16'd0);
    ifc.BUSY = 1'b0;
    tick();
    chk("mid_rst_regrant", 16'({ifc.GRANT, ifc.CMD, ifc.ADDR}), 16'({2'b01, 4'h4, 6'h02}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
